imem_loader: RTL and testbench

Host-side programmer that drives the instruction-memory programming port (imem_prog_we/addr/wdata) of the fetch stage. It consumes a byte stream over a valid/ready handshake and parses a 4-byte header (start address, word count). It assembles little-endian 32-bit words and issues one single-cycle write per word. While loading it asserts cpu_hold so the pipeline is frozen.

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream programmer for the instruction-memory programming port.
// Parses a 4-byte header (start word address, word count), then packs
// little-endian 32-bit words and issues one single-cycle write per word.
// The CPU pipeline is held (cpu_hold) for the whole load, including the last write.
//
// state | meaning
// IDLE  | waiting for start; in_ready low, pipeline free
// HDR   | accepting addr[7:0], addr[15:8], count[7:0], count[15:8]
// DATA  | accepting word bytes, one write per 4 bytes
// DONE  | single-cycle completion; final write pulse coincides here
module imem_loader #(
  parameter int IMEM_ADDR_WIDTH = 9,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       imem_prog_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_prog_addr,
  output logic [31:0]                imem_prog_wdata,
  output logic                       busy,
  output logic                       cpu_hold,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       words_written
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                 r_state;
  logic [1:0]                 r_idx;
  logic [23:0]                r_asm;
  logic [IMEM_ADDR_WIDTH-1:0] r_waddr;
  logic [CNT_WIDTH-1:0]       r_remaining;
  logic                       r_we;
  logic [IMEM_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                r_wdata;
  logic                       r_busy;
  logic                       r_done;
  logic [CNT_WIDTH-1:0]       r_ww;

  logic [1:0]           w_state_nxt;
  logic                 w_in_ready;
  logic                 w_xfer;
  logic                 w_last_byte;
  logic [CNT_WIDTH-1:0] w_cnt_hdr;
  logic [31:0]          w_word;

  // in_ready is a pure state decode so it never depends on in_valid
  assign w_in_ready  = (r_state == S_HDR) || (r_state == S_DATA);
  assign w_xfer      = in_valid && w_in_ready;
  assign w_last_byte = w_xfer && (r_idx == 2'd3);
  // count bits above CNT_WIDTH are dropped by the cast
  assign w_cnt_hdr   = CNT_WIDTH'({in_data, r_asm[7:0]});
  assign w_word      = {in_data, r_asm};

  assign in_ready        = w_in_ready;
  assign imem_prog_we    = r_we;
  assign imem_prog_addr  = r_addr;
  assign imem_prog_wdata = r_wdata;
  assign busy            = r_busy;
  assign cpu_hold        = r_busy;
  assign done            = r_done;
  assign words_written   = r_ww;

  // next-state decode; abort outranks everything, including start in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && !abort) w_state_nxt = S_HDR;
      S_HDR: begin
        if (abort)
          w_state_nxt = S_IDLE;
        else if (w_last_byte)
          w_state_nxt = (w_cnt_hdr == '0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        if (abort)
          w_state_nxt = S_IDLE;
        else if (w_last_byte && (r_remaining == CNT_WIDTH'(1)))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // header capture, word assembly and the registered write/status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_asm       <= '0;
      r_waddr     <= '0;
      r_remaining <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ww        <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= (w_state_nxt == S_DONE);
      r_busy <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (start && !abort) r_ww <= '0;
        end
        S_HDR: begin
          if (abort) begin
            r_idx <= '0;
          end else if (w_xfer) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0:    r_asm[7:0]  <= in_data;
              2'd1:    r_waddr     <= IMEM_ADDR_WIDTH'({in_data, r_asm[7:0]});
              2'd2:    r_asm[7:0]  <= in_data;
              default: r_remaining <= w_cnt_hdr;
            endcase
          end
        end
        S_DATA: begin
          if (abort) begin
            r_idx <= '0;
          end else if (w_xfer) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_asm[7:0]   <= in_data;
              2'd1: r_asm[15:8]  <= in_data;
              2'd2: r_asm[23:16] <= in_data;
              default: begin
                r_we        <= 1'b1;
                r_wdata     <= w_word;
                r_addr      <= r_waddr;
                r_waddr     <= r_waddr + IMEM_ADDR_WIDTH'(1);
                r_remaining <= r_remaining - CNT_WIDTH'(1);
                r_ww        <= r_ww + CNT_WIDTH'(1);
              end
            endcase
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete loads plus hand-written
// abort and asynchronous-reset sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        imem_prog_we;
  logic [8:0]  imem_prog_addr;
  logic [31:0] imem_prog_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [15:0] words_written;

  imem_loader #(.IMEM_ADDR_WIDTH(9), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_prog_we(imem_prog_we), .imem_prog_addr(imem_prog_addr),
    .imem_prog_wdata(imem_prog_wdata), .busy(busy), .cpu_hold(cpu_hold),
    .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // write/done monitor, sampled on the falling edge
  logic [8:0]  mon_addr [0:63];
  logic [31:0] mon_data [0:63];
  int wr_n = 0;
  int done_cnt = 0;
  int done_we = 0;
  int pulse_err = 0;
  logic prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_prog_we) begin
      mon_addr[wr_n & 63] <= imem_prog_addr;
      mon_data[wr_n & 63] <= imem_prog_wdata;
      wr_n <= wr_n + 1;
      if (prev_we) pulse_err <= pulse_err + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (imem_prog_we) done_we <= done_we + 1;
    end
    prev_we <= imem_prog_we;
  end

  typedef struct packed {
    logic [15:0]      addr;
    logic [15:0]      cnt;
    logic [2:0][31:0] w;
    logic [2:0][8:0]  ea;
    logic [3:0]       gap;
    logic             poke;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // present one byte after an idle gap; returns #1 after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    tick(gap);
    in_valid = 1'b1;
    in_data  = b;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick(1);
      guard++;
    end
    chk("ready_wait_expired", 32'(guard >= 20), 32'd0);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      send_byte(tmp[7:0], $urandom_range(0, gap));
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int b_wr, b_done, b_dwe, n, g;
    b_wr = wr_n; b_done = done_cnt; b_dwe = done_we;
    n = int'(v.cnt);
    g = int'(v.gap);
    do_start();
    chk($sformatf("v%0d busy_after_start", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d ready_in_hdr", id), 32'(in_ready), 32'd1);
    send_byte(v.addr[7:0], $urandom_range(0, g));
    send_byte(v.addr[15:8], $urandom_range(0, g));
    if (v.poke) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
    end
    send_byte(v.cnt[7:0], $urandom_range(0, g));
    send_byte(v.cnt[15:8], $urandom_range(0, g));
    for (int k = 0; k < n; k++) send_word(v.w[k], g);
    chk($sformatf("v%0d done_at_end", id), 32'(done), 32'd1);
    chk($sformatf("v%0d hold_at_end", id), 32'(cpu_hold), 32'd1);
    chk($sformatf("v%0d ready_in_done", id), 32'(in_ready), 32'd0);
    chk($sformatf("v%0d we_with_done", id), 32'(imem_prog_we), 32'(n != 0));
    if (n != 0) begin
      chk($sformatf("v%0d last_addr", id), 32'(imem_prog_addr), 32'(v.ea[n-1]));
      chk($sformatf("v%0d last_data", id), imem_prog_wdata, v.w[n-1]);
    end
    tick(1);
    chk($sformatf("v%0d done_one_cycle", id), 32'(done), 32'd0);
    chk($sformatf("v%0d busy_released", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d hold_released", id), 32'(cpu_hold), 32'd0);
    chk($sformatf("v%0d we_after", id), 32'(imem_prog_we), 32'd0);
    chk($sformatf("v%0d words_written", id), 32'(words_written), 32'(n));
    chk($sformatf("v%0d write_count", id), 32'(wr_n - b_wr), 32'(n));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("v%0d w%0d addr", id, k), 32'(mon_addr[(b_wr + k) & 63]), 32'(v.ea[k]));
      chk($sformatf("v%0d w%0d data", id, k), mon_data[(b_wr + k) & 63], v.w[k]);
    end
    chk($sformatf("v%0d done_pulses", id), 32'(done_cnt - b_done), 32'd1);
    chk($sformatf("v%0d done_with_we", id), 32'(done_we - b_dwe), 32'(n != 0));
  endtask

  initial begin
    int b_wr, b_done;

    //          addr      cnt    w[2]          w[1]          w[0]            ea[2]   ea[1]   ea[0]   gap poke
    vecs[0] = '{16'h0010, 16'd2, {32'h0,        32'hDEADBEEF, 32'h12345678}, {9'h000, 9'h011, 9'h010}, 4'd0, 1'b0};
    vecs[1] = '{16'h0000, 16'd0, {32'h0,        32'h0,        32'h0},        {9'h000, 9'h000, 9'h000}, 4'd0, 1'b0};
    vecs[2] = '{16'h01FF, 16'd2, {32'h0,        32'hC3C30002, 32'hA5A50001}, {9'h000, 9'h000, 9'h1FF}, 4'd0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'd1, {32'h0,        32'h0,        32'h0BADF00D}, {9'h000, 9'h000, 9'h1FF}, 4'd0, 1'b0};
    vecs[4] = '{16'h0010, 16'd2, {32'h0,        32'hDEADBEEF, 32'h12345678}, {9'h000, 9'h011, 9'h010}, 4'd5, 1'b1};
    vecs[5] = '{16'h01FE, 16'd3, {32'h55AA00FF, 32'h01020304, 32'hCAFEF00D}, {9'h000, 9'h1FF, 9'h1FE}, 4'd5, 1'b1};

    #3;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst we", 32'(imem_prog_we), 32'd0);
    chk("rst addr", 32'(imem_prog_addr), 32'd0);
    chk("rst wdata", imem_prog_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst words_written", 32'(words_written), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // start together with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort busy", 32'(busy), 32'd0);
    chk("start_abort in_ready", 32'(in_ready), 32'd0);

    // abort after two bytes of the second word
    b_wr = wr_n; b_done = done_cnt;
    do_start();
    send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h12345678, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort cpu_hold", 32'(cpu_hold), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd0);
    tick(2);
    chk("abort writes", 32'(wr_n - b_wr), 32'd1);
    chk("abort w0 addr", 32'(mon_addr[b_wr & 63]), 32'h010);
    chk("abort w0 data", mon_data[b_wr & 63], 32'h12345678);
    chk("abort no done", 32'(done_cnt - b_done), 32'd0);
    chk("abort words_written", 32'(words_written), 32'd1);

    // abort on the edge that would complete a word: that word is dropped
    b_wr = wr_n; b_done = done_cnt;
    do_start();
    send_byte(8'h20, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    in_valid = 1'b1; in_data = 8'h44; abort = 1'b1;
    tick(1);
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_edge we", 32'(imem_prog_we), 32'd0);
    chk("abort_edge busy", 32'(busy), 32'd0);
    tick(2);
    chk("abort_edge writes", 32'(wr_n - b_wr), 32'd0);
    chk("abort_edge no done", 32'(done_cnt - b_done), 32'd0);
    chk("abort_edge words_written", 32'(words_written), 32'd0);

    // a full load after aborts starts counting from zero again
    run_vec(vecs[0], 10);

    // asynchronous reset in the middle of DATA
    b_wr = wr_n;
    do_start();
    send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h12345678, 0);
    send_byte(8'hEF, 0);
    chk("pre_reset busy", 32'(busy), 32'd1);
    chk("pre_reset words_written", 32'(words_written), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async in_ready", 32'(in_ready), 32'd0);
    chk("async we", 32'(imem_prog_we), 32'd0);
    chk("async addr", 32'(imem_prog_addr), 32'd0);
    chk("async wdata", imem_prog_wdata, 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async cpu_hold", 32'(cpu_hold), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async words_written", 32'(words_written), 32'd0);
    in_valid = 1'b1; in_data = 8'hBE;
    tick(2);
    #3;
    reset_n = 1'b1;
    tick(3);
    in_valid = 1'b0;
    chk("post_reset in_ready", 32'(in_ready), 32'd0);
    chk("post_reset busy", 32'(busy), 32'd0);
    chk("post_reset writes", 32'(wr_n - b_wr), 32'd1);

    run_vec(vecs[3], 11);

    chk("we pulse width", 32'(pulse_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case a wait hangs outside the bounded loops
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
